// File: rtl/parallel_to_serial.sv
// Result-word serializer: loads one N-bit word and streams it MSB-byte first
// over a valid/ready byte handshake, then pulses done for one cycle.
module parallel_to_serial #(
  parameter int unsigned N         = 64,
  parameter int unsigned Ndiv8log2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_data,
  output logic         rx_ready,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done
);

  // A single-byte word still needs a 1-bit counter register.
  localparam int unsigned CW = (Ndiv8log2 > 0) ? Ndiv8log2 : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rx_ready_q, rx_ready_d;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          state_d = SEND;
          shift_d = rx_data;
          cnt_d   = CW'(N / 8 - 1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (cnt_q != '0) begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q - CW'(1);
          end else begin
            state_d = DONE_ST;
          end
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_valid_d = (state_d == SEND);
    busy_d     = (state_d == SEND);
    done_d     = (state_d == DONE_ST);
    rx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // The top byte of the shift register is the byte on offer; it holds in IDLE/DONE.
  assign tx_byte  = shift_q[N-1 -: 8];
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_ready = rx_ready_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: directed and randomized words against a
// byte-extraction reference model, for N=64 and N=8 instances.
module tb_parallel_to_serial;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rx_valid, rx_ready, tx_valid, tx_ready, busy, done;
  logic [63:0] rx_data;
  logic [7:0]  tx_byte;

  logic        s_rx_valid, s_rx_ready, s_tx_valid, s_tx_ready, s_busy, s_done;
  logic [7:0]  s_rx_data, s_tx_byte;

  int checks = 0;
  int errors = 0;

  parallel_to_serial #(.N(64), .Ndiv8log2(3)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  parallel_to_serial #(.N(8), .Ndiv8log2(0)) dut8 (
    .clk(clk), .rst(rst), .rx_valid(s_rx_valid), .rx_data(s_rx_data),
    .rx_ready(s_rx_ready), .tx_byte(s_tx_byte), .tx_valid(s_tx_valid),
    .tx_ready(s_tx_ready), .busy(s_busy), .done(s_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: byte k of an nb-byte word, most significant byte first.
  function automatic logic [7:0] ref_byte(input logic [63:0] w, input int k, input int nb);
    logic [63:0] sh;
    sh = w >> (8 * (nb - 1 - k));
    return sh[7:0];
  endfunction

  // mode 0: tx_ready always 1; 1: pattern 1,0,0; 2: random.
  task automatic run_word(input logic [63:0] w, input int mode, input bit poke,
                          input int abort_after);
    int idx = 0;
    int cyc = 0;
    int phase = 0;
    bit rdy;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = w; tx_ready = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = '0;
    while (idx < 8 && cyc < 200) begin
      check("byte", tx_byte, ref_byte(w, idx, 8));
      check("send_ctl{valid,busy,done,ready}", {tx_valid, busy, done, rx_ready}, 4'b1100);
      if (abort_after >= 0 && idx == abort_after) begin
        #2 rst = 1'b0;
        #1 check("abort_ctl{valid,busy,done,ready}", {tx_valid, busy, done, rx_ready}, 4'b0001);
        @(negedge clk);
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done{valid,busy,done,ready}", {tx_valid, busy, done, rx_ready}, 4'b0001);
        end
        return;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 3 == 0) : 1'($urandom_range(0, 1));
      phase++;
      tx_ready = rdy;
      if (poke) begin rx_valid = 1'b1; rx_data = '1; end
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
    end
    if (cyc >= 200) check("timeout", 1'b0, 1'b1);
    tx_ready = 1'b0;
    check("done_ctl{valid,busy,done,ready}", {tx_valid, busy, done, rx_ready}, 4'b0010);
    check("byte_hold", tx_byte, ref_byte(w, 7, 8));
    @(negedge clk);
    check("idle_ctl{valid,busy,done,ready}", {tx_valid, busy, done, rx_ready}, 4'b0001);
    rx_valid = 1'b0; rx_data = '0;
  endtask

  initial begin
    logic [7:0]  b;
    logic [63:0] w;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    s_rx_valid = 1'b0; s_rx_data = '0; s_tx_ready = 1'b0;

    // Asynchronous reset mid-cycle, then idle for 10 cycles.
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_ctl{valid,busy,done,ready}", {tx_valid, busy, done, rx_ready}, 4'b0001);
    check("reset_byte", tx_byte, 8'h00);
    check("reset8_ctl{valid,busy,done,ready}", {s_tx_valid, s_busy, s_done, s_rx_ready}, 4'b0001);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_valid", tx_valid, 1'b0);
    end

    run_word(64'hAABBCCDD11223344, 0, 1'b0, -1);
    run_word(64'hAABBCCDD11223344, 1, 1'b0, -1);
    run_word(64'hAABBCCDD11223344, 2, 1'b1, -1);
    run_word(64'h0102030405060708, 0, 1'b0, -1);
    run_word(64'h1122334455667788, 0, 1'b0, 3);
    run_word(64'hDEADBEEFCAFEF00D, 0, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      w = {32'($urandom), 32'($urandom)};
      run_word(w, 2, 1'($urandom_range(0, 1)), -1);
    end

    // N=8 instance: single byte, then done, then ready.
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h5A : 8'($urandom);
      @(negedge clk);
      s_rx_valid = 1'b1; s_rx_data = b;
      @(negedge clk);
      s_rx_valid = 1'b0;
      check("n8_byte", s_tx_byte, b);
      check("n8_send{valid,busy,done,ready}", {s_tx_valid, s_busy, s_done, s_rx_ready}, 4'b1100);
      s_tx_ready = 1'b1;
      @(negedge clk);
      s_tx_ready = 1'b0;
      check("n8_done{valid,busy,done,ready}", {s_tx_valid, s_busy, s_done, s_rx_ready}, 4'b0010);
      @(negedge clk);
      check("n8_idle{valid,busy,done,ready}", {s_tx_valid, s_busy, s_done, s_rx_ready}, 4'b0001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
